// File: rtl/led_pattern_gen_if.sv
// Control and LED drive bundle for led_pattern_gen.
// The master side selects mode and pattern; the slave side returns the registered LED drive and tick.
interface led_pattern_gen_if #(
  parameter int unsigned N_LED = 8
);
  logic             enable;
  logic [1:0]       mode;
  logic [N_LED-1:0] pattern;
  logic [N_LED-1:0] led;
  logic             tick;

  modport master (output enable, mode, pattern, input led, tick);
  modport slave  (input enable, mode, pattern, output led, tick);
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: shared tick prescaler feeding count, scan, breathe and static sources.
// All generators run concurrently; mode only picks which one is registered onto led.
module led_pattern_gen #(
  parameter int unsigned N_LED = 8,
  parameter int unsigned DIV   = 2500000,
  parameter int unsigned PWM_W = 8
) (
  input logic               clk,
  input logic               rst,
  led_pattern_gen_if.slave  bus
);

  localparam int unsigned PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [PWM_W-1:0] DUTY_TOP  = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] DUTY_TURN = {{(PWM_W-1){1'b1}}, 1'b0};
  localparam logic [PWM_W-1:0] DUTY_ONE  = PWM_W'(1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_STATIC  = 2'd3
  } mode_e;

  logic [PRE_W-1:0] pre_q,  pre_nxt;
  logic             tick_q, tick_nxt;
  logic [N_LED-1:0] cnt_q,  cnt_nxt;
  logic [N_LED-1:0] pos_q,  pos_nxt;
  dir_e             sdir_q, sdir_nxt;
  logic [PWM_W-1:0] duty_q, duty_nxt;
  dir_e             bdir_q, bdir_nxt;
  logic [PWM_W-1:0] pwm_q,  pwm_nxt;
  logic [N_LED-1:0] led_q,  led_nxt;
  mode_e            mode_sel;
  logic             breathe_on;

  assign mode_sel   = mode_e'(bus.mode);
  assign breathe_on = (pwm_q < duty_q);

  // State register for prescaler, generators and output drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
      pos_q  <= N_LED'(1);
      sdir_q <= DIR_UP;
      duty_q <= '0;
      bdir_q <= DIR_UP;
      pwm_q  <= '0;
      led_q  <= '0;
    end else begin
      pre_q  <= pre_nxt;
      tick_q <= tick_nxt;
      cnt_q  <= cnt_nxt;
      pos_q  <= pos_nxt;
      sdir_q <= sdir_nxt;
      duty_q <= duty_nxt;
      bdir_q <= bdir_nxt;
      pwm_q  <= pwm_nxt;
      led_q  <= led_nxt;
    end
  end

  // Next-state and output selection
  always_comb begin
    pre_nxt  = pre_q;
    tick_nxt = 1'b0;
    cnt_nxt  = cnt_q;
    pos_nxt  = pos_q;
    sdir_nxt = sdir_q;
    duty_nxt = duty_q;
    bdir_nxt = bdir_q;
    pwm_nxt  = pwm_q + PWM_W'(1);
    led_nxt  = '0;

    if (bus.enable) begin
      tick_nxt = (pre_q == PRE_LAST);
      pre_nxt  = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    end

    if (tick_q) begin
      cnt_nxt = cnt_q + N_LED'(1);

      // Scanner turns at an end on the same tick, so end positions never repeat
      if (N_LED > 1) begin
        if (sdir_q == DIR_UP) begin
          if (pos_q[N_LED-1]) begin
            sdir_nxt = DIR_DOWN;
            pos_nxt  = pos_q >> 1;
          end else begin
            pos_nxt  = pos_q << 1;
          end
        end else begin
          if (pos_q[0]) begin
            sdir_nxt = DIR_UP;
            pos_nxt  = pos_q << 1;
          end else begin
            pos_nxt  = pos_q >> 1;
          end
        end
      end

      // Breathe direction flips on the tick that lands on an endpoint
      if (bdir_q == DIR_UP) begin
        duty_nxt = duty_q + PWM_W'(1);
        if (duty_q == DUTY_TURN) bdir_nxt = DIR_DOWN;
      end else begin
        duty_nxt = duty_q - PWM_W'(1);
        if (duty_q == DUTY_ONE) bdir_nxt = DIR_UP;
      end
    end

    case (mode_sel)
      MODE_COUNT:   led_nxt = cnt_q;
      MODE_SCAN:    led_nxt = pos_q;
      MODE_BREATHE: led_nxt = {N_LED{breathe_on}};
      MODE_STATIC:  led_nxt = bus.pattern;
      default:      led_nxt = '0;
    endcase
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;

  // DUTY_TOP documents the turn point; the comparison uses DUTY_TURN one step earlier
  logic unused_top;
  assign unused_top = ^DUTY_TOP;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized bench for led_pattern_gen over three parameter sets, checked against
// a model that derives every output from elapsed tick/enable/cycle counts.
module tb_led_pattern_gen;

  localparam int NCYC = 30000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] pat;

  int n_checks = 0;
  int n_errors = 0;

  int nl_p [3] = '{8, 4, 1};
  int dv_p [3] = '{4, 2, 2};
  int pw_p [3] = '{8, 3, 2};

  int e_m   [3];
  int t_m   [3];
  int c_m   [3];
  int led_m [3];
  bit tick_m[3];

  always #5 clk = ~clk;

  led_pattern_gen_if #(.N_LED(8)) bus0 ();
  led_pattern_gen_if #(.N_LED(4)) bus1 ();
  led_pattern_gen_if #(.N_LED(1)) bus2 ();

  led_pattern_gen #(.N_LED(8), .DIV(4), .PWM_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  led_pattern_gen #(.N_LED(4), .DIV(2), .PWM_W(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  led_pattern_gen #(.N_LED(1), .DIV(2), .PWM_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.enable = enable;
  assign bus1.enable = enable;
  assign bus2.enable = enable;
  assign bus0.mode   = mode;
  assign bus1.mode   = mode;
  assign bus2.mode   = mode;
  assign bus0.pattern = pat;
  assign bus1.pattern = pat[3:0];
  assign bus2.pattern = pat[0:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scanner position after t ticks: bounces 0..n-1..0 with period 2(n-1)
  function automatic int scan_val(input int n, input int t);
    int per, p, idx;
    if (n == 1) return 1;
    per = 2 * (n - 1);
    p   = t % per;
    idx = (p < n) ? p : per - p;
    return 1 << idx;
  endfunction

  // Breathe duty after t ticks: triangle 0..max..0 with period 2*max
  function automatic int duty_val(input int w, input int t);
    int mx, p;
    mx = (1 << w) - 1;
    p  = t % (2 * mx);
    return (p <= mx) ? p : 2 * mx - p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      e_m[i] = 0; t_m[i] = 0; c_m[i] = 0; led_m[i] = 0; tick_m[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit en, input logic [1:0] md, input logic [7:0] p8);
    int n, w, d, mask;
    for (int i = 0; i < 3; i++) begin
      n = nl_p[i]; w = pw_p[i]; d = dv_p[i];
      mask = (1 << n) - 1;
      case (md)
        2'd0: led_m[i] = t_m[i] % (1 << n);
        2'd1: led_m[i] = scan_val(n, t_m[i]);
        2'd2: led_m[i] = ((c_m[i] % (1 << w)) < duty_val(w, t_m[i])) ? mask : 0;
        default: led_m[i] = int'(p8) & mask;
      endcase
      t_m[i]    = t_m[i] + (tick_m[i] ? 1 : 0);
      tick_m[i] = en && ((e_m[i] % d) == d - 1);
      e_m[i]    = e_m[i] + (en ? 1 : 0);
      c_m[i]    = c_m[i] + 1;
    end
  endtask

  task automatic compare_all(input string phase, input int cyc);
    logic [31:0] gl [3];
    logic [31:0] gt [3];
    gl[0] = 32'(bus0.led); gt[0] = 32'(bus0.tick);
    gl[1] = 32'(bus1.led); gt[1] = 32'(bus1.tick);
    gl[2] = 32'(bus2.led); gt[2] = 32'(bus2.tick);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s led%0d cyc%0d", phase, i, cyc), gl[i], 32'(led_m[i]));
      check($sformatf("%s tick%0d cyc%0d", phase, i, cyc), gt[i], 32'(tick_m[i]));
    end
  endtask

  initial begin
    int rst_left;
    int en_off;
    rst    = 1'b1;
    enable = 1'b0;
    mode   = 2'd0;
    pat    = 8'h00;
    rst_left = 0;
    en_off   = 0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset", 0);
    rst = 1'b0;
    enable = 1'b1;

    for (int cyc = 1; cyc <= NCYC; cyc++) begin
      if (en_off == 0 && $urandom_range(0, 63) == 0) en_off = $urandom_range(1, 12);
      enable = (en_off == 0);
      if (en_off > 0) en_off--;
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  pat  = 8'($urandom);
      if (cyc == 5000 || (rst_left == 0 && $urandom_range(0, 7999) == 0))
        rst_left = $urandom_range(1, 3);

      if (rst_left > 0) begin
        model_reset();
        if (!rst) begin
          rst = 1'b1;
          #1;
          compare_all("async_rst", cyc);
        end
        rst_left--;
      end else begin
        rst = 1'b0;
        model_edge(enable, mode, pat);
      end

      @(negedge clk);
      compare_all("run", cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
